lif_update_engine: RTL
======================

// Module: lif_update_engine
// PURPOSE
//  Read-modify-write controller for the membrane-potential RAM: the client end of its read/write ports.
//  Accepts synaptic events (neuron index + signed weight) and reads that neuron's potential.
//  Integrates the weight (with optional leak), compares against threshold, writes back, and emits a spike event on fire.
//  Sits between the synapse/event scheduler and the potential memory; spikes go to the output spike queue.
// PARAMETERS
//  WIDTH    32   potential word width, two's-complement signed
//  DEPTH    16   neurons in potential RAM; address width AW = $clog2(DEPTH)
//  WWIDTH   8    synaptic weight width, signed
//  THRESH   100  firing threshold (signed, WIDTH bits); fire when potential >= THRESH
//  V_RESET  0    potential written back after a fire
//  LEAK     1    per-event leak subtracted when LIF_LEAK_EN is defined (unsigned, < 2^(WIDTH-1))
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous, active-low reset
//  in_valid        in   1       event valid
//  in_ready        out  1       engine can accept event (high only in IDLE)
//  in_addr         in   AW      target neuron index
//  in_weight       in   WWIDTH  signed synaptic weight
//  mem_read_en     out  1       potential RAM read enable
//  mem_read_addr   out  AW      potential RAM read address
//  mem_read_data   in   WIDTH   potential RAM registered read data (valid 1 cycle after read_en)
//  mem_write_en    out  1       potential RAM write enable
//  mem_write_addr  out  AW      potential RAM write address
//  mem_write_data  out  WIDTH   potential RAM write data
//  spike_valid     out  1       spike event valid
//  spike_ready     in   1       downstream accepts spike
//  spike_addr      out  AW      index of neuron that fired
//  spike_cnt       out  16      total spikes delivered, saturates at 16'hFFFF
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; addr/weight/result regs, spike_addr, spike_cnt = 0.
//  Reset also clears spike_valid, mem_read_en, mem_write_en, mem_write_data = 0; in_ready = 1.
//  FSM, one event in flight: IDLE -> RD -> CALC -> WR -> (SPK | IDLE).
//  IDLE: in_ready=1. On in_valid: latch in_addr, in_weight; go RD.
//  RD (1 cyc): mem_read_en=1, mem_read_addr=latched addr; go CALC.
//  CALC (1 cyc): mem_read_data valid this cycle.
//   - sum = sat(p + sext(weight)) at WIDTH bits.
//   - Signed saturation: clamp to 2^(WIDTH-1)-1 / -2^(WIDTH-1), never wraps.
//   - fire = (sum >= THRESH); result = fire ? V_RESET : sum; register both; go WR.
//  WR (1 cyc): mem_write_en=1, addr=latched addr, data=result. fire ? go SPK (spike_valid=1, spike_addr=addr) : go IDLE.
//  SPK: spike_valid held 1, spike_addr stable until spike_ready=1.
//   - On that cycle: spike_cnt += 1 (saturating); go IDLE.
//  mem_* and spike_valid decode from registered state only; all low outside their states.
//  mem_read_addr/mem_write_addr hold latched addr in all states (don't-care when enables low).
//  Latency: event accept -> write 3 cycles; non-firing throughput 1 event / 4 cycles (IDLE included).
//  Hazards: write in WR commits before next RD can issue, so back-to-back events to same neuron need no forwarding.
//  Spike backpressure: engine stalls in SPK; in_ready=0 until spike accepted. Potential already written.
//  Reset mid-operation: returns to IDLE immediately; in-flight event and any pending spike dropped.
//   - A write not yet in WR is never issued.
//  Out-of-range in_addr (>= DEPTH when DEPTH not power of 2): behaviour undefined; scheduler guarantees range.
// CONFIGURATION
//  LIF_LEAK_EN defined: sum = sat(sat(p + sext(weight)) - LEAK) in CALC, before threshold compare.
//  LIF_LEAK_EN undefined: no leak; sum = sat(p + sext(weight)); LEAK parameter unused.
//  Timing and FSM identical either way.
// TESTING
//  T1 reset: rst=0 mid-SPK -> spike_valid=0, busy=0, in_ready=1, spike_cnt=0.
//  T1 after release: first accepted event reads at RD.
//  T2 sub-threshold (no leak): p[3]=0, event (3,+50) -> read addr 3, write 50 three cycles after accept, no spike.
//  T3 fire: p[3]=60, event (3,+50) -> write V_RESET=0 to addr 3; spike_valid=1, spike_addr=3.
//  T3 spike_ready held 0 for 5 cycles -> in_ready=0 throughout; on accept spike_cnt=1.
//  T4 back-to-back same neuron: events (5,+40)x3 from p=0 -> writes 40, 80, then fire (120>=100) writing 0, one spike.
//  T5 saturation: p[0]=32'h7FFFFFF0, event (0,+127) -> sum 32'h7FFFFFFF, fires.
//  T5 negative: p[1]=32'h80000005, event (1,-128) -> writes 32'h80000000, no spike.
//  T6 LIF_LEAK_EN, LEAK=1: p[2]=0, event (2,+10) -> writes 9; event (2,-9) -> writes -1 (32'hFFFFFFFF).

Source files
------------

// File: rtl/lif_update_engine.sv
// Leaky integrate-and-fire read-modify-write engine for the membrane-potential RAM.
// Optional leak: define LIF_LEAK_EN to subtract LEAK on every event before the threshold compare.
module lif_update_engine #(
    parameter int                      WIDTH   = 32,
    parameter int                      DEPTH   = 16,
    parameter int                      WWIDTH  = 8,
    parameter logic signed [WIDTH-1:0] THRESH  = 100,
    parameter logic signed [WIDTH-1:0] V_RESET = 0,
    parameter logic [WIDTH-1:0]        LEAK    = 1,
    localparam int                     AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic [WWIDTH-1:0] in_weight,
    output logic              mem_read_en,
    output logic [AW-1:0]     mem_read_addr,
    input  logic [WIDTH-1:0]  mem_read_data,
    output logic              mem_write_en,
    output logic [AW-1:0]     mem_write_addr,
    output logic [WIDTH-1:0]  mem_write_data,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [AW-1:0]     spike_addr,
    output logic [15:0]       spike_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE = 3'd0, RD = 3'd1, CALC = 3'd2, WR = 3'd3, SPK = 3'd4} state_t;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef LIF_LEAK_EN
    localparam logic [WIDTH-1:0] LEAK_EFF = LEAK;
`else
    localparam logic [WIDTH-1:0] LEAK_EFF = {WIDTH{1'b0}};
`endif
    // Leak folded in as a saturating add of its two's-complement negation (LEAK < 2^(WIDTH-1)).
    localparam logic signed [WIDTH-1:0] LEAK_NEG = $signed(~LEAK_EFF + {{(WIDTH-1){1'b0}}, 1'b1});

    state_t                   state_r, state_s;
    logic [AW-1:0]            addr_r;
    logic [WWIDTH-1:0]        weight_r;
    logic signed [WIDTH-1:0]  result_r;
    logic                     fire_r;
    logic [15:0]              spike_cnt_r;
    logic signed [WIDTH-1:0]  sum_s;
    logic                     fire_s;

    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            sat_add = s[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[WIDTH-1:0];
        end
    endfunction

    // Integrate weight (and leak) into the potential read this cycle, then compare with threshold.
    always_comb begin
        sum_s  = sat_add(sat_add($signed(mem_read_data),
                                 {{(WIDTH-WWIDTH){weight_r[WWIDTH-1]}}, weight_r}),
                         LEAK_NEG);
        fire_s = (sum_s >= THRESH);
    end

    // Next-state logic for the single-event-in-flight FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid) state_s = RD;   else state_s = IDLE;
            RD:      state_s = CALC;
            CALC:    state_s = WR;
            WR:      if (fire_r) state_s = SPK;    else state_s = IDLE;
            SPK:     if (spike_ready) state_s = IDLE; else state_s = SPK;
            default: state_s = IDLE;
        endcase
    end

    // State, event latch, computed result and saturating spike counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            addr_r      <= {AW{1'b0}};
            weight_r    <= {WWIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            fire_r      <= 1'b0;
            spike_cnt_r <= 16'd0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && in_valid) begin
                addr_r   <= in_addr;
                weight_r <= in_weight;
            end
            if (state_r == CALC) begin
                fire_r   <= fire_s;
                result_r <= fire_s ? V_RESET : sum_s;
            end
            if (state_r == SPK && spike_ready && spike_cnt_r != 16'hFFFF) begin
                spike_cnt_r <= spike_cnt_r + 16'd1;
            end
        end
    end

    assign in_ready       = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign mem_read_en    = (state_r == RD);
    assign mem_read_addr  = addr_r;
    assign mem_write_en   = (state_r == WR);
    assign mem_write_addr = addr_r;
    assign mem_write_data = result_r;
    assign spike_valid    = (state_r == SPK);
    assign spike_addr     = addr_r;
    assign spike_cnt      = spike_cnt_r;

endmodule
